bcd_12bit_to_binary_converter: RTL
==================================

# bcd_12bit_to_binary_converter

Sequential 3-digit packed-BCD to binary converter: the inverse of the display path's binary-to-BCD stage. It converts decimal values entered or received as BCD, 000–999, back into the binary operand width used by the datapath. The block uses reverse double-dabble: one right shift plus per-digit correction per clock. It has a start/busy/done handshake.

## Interface
- `BINARY_DATA_SIZE`, default 8: width of `binary_data`. Legal range is 4–10. The internal result is always 10 bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `bcd_data`  in  12  packed BCD: [11:8] hundreds, [7:4] tens, [3:0] units. Sampled only on the accepting edge.
- `start_conversion`  in  1  request. Level-sampled in IDLE only.
- `binary_data`  out  BINARY_DATA_SIZE  result, held until the next completion or reset.
- `busy`  out  1  high from the accepting edge until completion.
- `conversion_complete`  out  1  one-cycle pulse when `binary_data` updates.
- `overflow`  out  1  result ≥ 2^BINARY_DATA_SIZE. Updated with each completion.
- `bcd_error`  out  1  invalid digit detected. Updated with each completion; see Configuration.

## Operation
- States:
  - IDLE: `start_conversion`=1 → load, go to CONVERT.
  - CONVERT: 10 iterations, then go to FINISH.
  - FINISH: update outputs, go to IDLE.
- Load:
  - 22-bit shift register = {`bcd_data`, 10'b0}.
  - Iteration counter = 0.
  - `busy`=1.
  - With the check enabled, digit validity is also captured here.
- Iteration, repeated 10 times (4-bit counter, 0..10):
  - Shift the whole register right by 1, zero-filling the MSB.
  - Then, for each of the three BCD nibbles [21:18], [17:14], [13:10]: if nibble ≥ 8, subtract 3. Each nibble is corrected independently.
- After 10 iterations, bits [9:0] hold the binary value and the BCD field is zero.
- Completion:
  - `binary_data` = result[BINARY_DATA_SIZE-1:0], truncated, not saturated.
  - `overflow` = |result[9:BINARY_DATA_SIZE]. This is always 0 when BINARY_DATA_SIZE = 10.
  - `conversion_complete`=1 for one cycle; `busy`=0.
- `start_conversion` while not IDLE is ignored and not queued.
- `bcd_data` changes after the accepting edge do not affect the current result.
- Reset values: state IDLE, `binary_data`=0, `busy`=0, `conversion_complete`=0, `overflow`=0, `bcd_error`=0, shift register 0, counter 0.
- Reset takes priority over every other event, including on the same edge as start or completion. Reset mid-conversion aborts with no completion pulse, and outputs return to reset values.

## Timing
- Accept edge k (IDLE, start=1): `busy` is high from after edge k.
- Iterations occur at edges k+1..k+10.
- Edge k+11 (FINISH):
  - `binary_data`, `overflow`, `bcd_error` update.
  - `conversion_complete` is high for cycle k+11..k+12.
  - `busy` is low after k+11.
- Latency from accept to outputs is 11 clocks. The earliest next accept is edge k+12.
- Start held continuously gives one conversion every 12 clocks.
- `binary_data` is stable between completions. No output is combinational from inputs.

## Configuration
- Macro `BCD_DIGIT_CHECK_EN`.
- Defined:
  - Each input nibble is compared against 9 at load.
  - If any nibble exceeds 9, the conversion still runs the full 11-cycle latency.
  - At completion: `bcd_error`=1, `binary_data`=0, `overflow`=0.
  - Valid inputs give `bcd_error`=0.
- Undefined:
  - No check logic is present, and `bcd_error` is tied to 0.
  - Results for invalid nibbles are unspecified; the bench must not check them.

## Test plan
- N=8, `bcd_data`=0x255, start at edge k → `conversion_complete` at k+11 with `binary_data`=255 (0xFF), `overflow`=0; `busy` high for exactly 11 cycles.
- N=8, 0x999 → `binary_data`=0xE7 (231), `overflow`=1. With N=10: 999 (0x3E7), `overflow`=0.
- 0x000 → 0; 0x128 → 0x80. Back-to-back with start held high: completions exactly 12 clocks apart. `bcd_data` changed mid-conversion does not alter the result.
- Start pulsed during busy is ignored: exactly one completion. Reset asserted at k+5 → no completion pulse, all outputs at reset values; a new start converts correctly.
- `BCD_DIGIT_CHECK_EN` defined, 0x1A3 → at k+11 `bcd_error`=1, `binary_data`=0. A following 0x099 → 99, `bcd_error`=0.

Source files
------------

// File: rtl/bcd_12bit_to_binary_converter_if.sv
// Handshake and data bundle for the 3-digit BCD to binary converter.
// The master drives the request; the slave (converter) returns the result and status.
interface bcd_12bit_to_binary_converter_if #(
  parameter int unsigned BINARY_DATA_SIZE = 8
);
  logic [11:0]                 bcd_data;
  logic                        start_conversion;
  logic [BINARY_DATA_SIZE-1:0] binary_data;
  logic                        busy;
  logic                        conversion_complete;
  logic                        overflow;
  logic                        bcd_error;

  modport master (
    output bcd_data, start_conversion,
    input  binary_data, busy, conversion_complete, overflow, bcd_error
  );

  modport slave (
    input  bcd_data, start_conversion,
    output binary_data, busy, conversion_complete, overflow, bcd_error
  );
endinterface

// File: rtl/bcd_12bit_to_binary_converter.sv
// Sequential packed-BCD (000-999) to binary converter using reverse double-dabble, one bit per clock.
// Optional digit validity check enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_12bit_to_binary_converter #(
  parameter int unsigned BINARY_DATA_SIZE = 8
) (
  input logic                               clk,
  input logic                               reset,
  bcd_12bit_to_binary_converter_if.slave    bus
);

  localparam logic [3:0] LastIter = 4'd9;

  typedef enum logic [1:0] {StIdle, StConvert, StFinish} state_e;

  state_e                      state_q, state_d;
  logic [21:0]                 sreg_q, sreg_d;
  logic [3:0]                  cnt_q, cnt_d;
  logic [BINARY_DATA_SIZE-1:0] bin_q, bin_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic                        ovf_q, ovf_d;
  logic [9:0]                  result;

`ifdef BCD_DIGIT_CHECK_EN
  logic inval_q, inval_d;
  logic err_q, err_d;
`endif

  // Shift right, then pull each BCD nibble back into range (inverse of the add-3 step).
  function automatic logic [21:0] dabble_step(input logic [21:0] s);
    logic [21:0] r;
    r = {1'b0, s[21:1]};
    for (int i = 0; i < 3; i++) begin
      if (r[10+4*i +: 4] >= 4'd8) r[10+4*i +: 4] = r[10+4*i +: 4] - 4'd3;
    end
    return r;
  endfunction

  assign result = sreg_q[9:0];

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    bin_d   = bin_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
`ifdef BCD_DIGIT_CHECK_EN
    inval_d = inval_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start_conversion) begin
          sreg_d  = {bus.bcd_data, 10'b0};
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = StConvert;
`ifdef BCD_DIGIT_CHECK_EN
          inval_d = (bus.bcd_data[11:8] > 4'd9) || (bus.bcd_data[7:4] > 4'd9) ||
                    (bus.bcd_data[3:0] > 4'd9);
`endif
        end
      end
      StConvert: begin
        sreg_d = dabble_step(sreg_q);
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == LastIter) state_d = StFinish;
      end
      StFinish: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = StIdle;
`ifdef BCD_DIGIT_CHECK_EN
        if (inval_q) begin
          bin_d = '0;
          ovf_d = 1'b0;
          err_d = 1'b1;
        end else begin
          bin_d = result[BINARY_DATA_SIZE-1:0];
          ovf_d = (result >> BINARY_DATA_SIZE) != 10'd0;
          err_d = 1'b0;
        end
`else
        bin_d = result[BINARY_DATA_SIZE-1:0];
        // Truncated bits above the output width flag overflow; always 0 at full width.
        ovf_d = (result >> BINARY_DATA_SIZE) != 10'd0;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      sreg_q  <= '0;
      cnt_q   <= '0;
      bin_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      inval_q <= 1'b0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      bin_q   <= bin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
`ifdef BCD_DIGIT_CHECK_EN
      inval_q <= inval_d;
      err_q   <= err_d;
`endif
    end
  end

  assign bus.binary_data         = bin_q;
  assign bus.busy                = busy_q;
  assign bus.conversion_complete = done_q;
  assign bus.overflow            = ovf_q;
`ifdef BCD_DIGIT_CHECK_EN
  assign bus.bcd_error           = err_q;
`else
  assign bus.bcd_error           = 1'b0;
`endif

endmodule
